diagonal_writeback: RTL and testbench
=====================================

// Module: diagonal_writeback
// PURPOSE
//  Downstream stage of update_computation. Takes the NewDiagonalX/NewDiagonalY results and their Done flags.
//  Tags each result with the diagonal address latched when the update started.
//  Queues the tagged results and writes them to the diagonal memory through a single stalling write port.
//  Pulses UpdateDone once both writes of the update have been accepted.
// PARAMETERS
//  ADDR_W  10  diagonal memory address width
//  DEPTH   4   write FIFO entries; legal range 2..16; power of two
// PORTS
//  clock         in   1        single clock; all logic on posedge
//  reset         in   1        synchronous, active-high
//  Start         in   1        begin an update; latch XAddr/YAddr; accepted only when StartReady=1
//  XAddr         in   ADDR_W   DiagonalX memory index of this update
//  YAddr         in   ADDR_W   DiagonalY memory index of this update
//  StartReady    out  1        1 when FSM is in IDLE
//  NewDiagonalX  in   48       result from update_computation
//  NewDiagonalY  in   48       result from update_computation
//  DiagonalXDone in   1        level or pulse; its rising edge marks NewDiagonalX valid
//  DiagonalYDone in   1        level or pulse; its rising edge marks NewDiagonalY valid
//  MemWrite      out  1        write request, held until accepted
//  MemSel        out  1        0 = X diagonal memory, 1 = Y diagonal memory
//  MemAddr       out  ADDR_W   write address
//  MemData       out  48       write data
//  MemReady      in   1        memory accepts the write when MemWrite && MemReady
//  UpdateDone    out  1        one-cycle pulse when the update is fully written
//  Error         out  1        sticky; cleared only by reset
// BEHAVIOUR
//  Reset
//   - StartReady=1; MemWrite=0; MemSel=0; MemAddr=0; MemData=0; UpdateDone=0; Error=0.
//   - FIFO empty, pending register empty, FSM in IDLE, edge-detect history regs = 0.
//   - A reset mid-operation discards queued entries; writes not yet accepted are never issued.
//  Edge detect
//   - XEdge = DiagonalXDone & ~XDonePrev; YEdge likewise (prev regs sampled every cycle).
//  FSM states: IDLE, WAIT_DONE, WAIT_WRITE
//   - IDLE: Start=1 -> latch XAddr/YAddr, clear gotX/gotY, go WAIT_DONE. An edge seen in IDLE sets Error; nothing is pushed.
//   - WAIT_DONE: each first edge pushes its entry and sets gotX/gotY. A second edge of the same kind sets Error and is dropped.
//     When gotX && gotY -> go WAIT_WRITE.
//   - WAIT_WRITE: when FIFO empty && pending empty && no write accepted this cycle -> UpdateDone=1 for one cycle, go IDLE.
//     The next cycle is IDLE, so StartReady rises the cycle after UpdateDone.
//   - Start outside IDLE is ignored; no Error.
//  Push
//   - Entry = {MemSel, addr, data}. Data captured from NewDiagonalX/Y in the edge cycle.
//   - Entry is visible at the FIFO head the next cycle.
//   - Simultaneous X and Y edges: X is pushed; Y goes to the pending register and is pushed the following cycle.
//     Pending has priority over new edges.
//   - FIFO full: the entry waits in pending. It cannot overflow with DEPTH>=2 (at most 2 entries per update).
//  Drain
//   - MemWrite = FIFO non-empty. MemSel/MemAddr/MemData = head entry, registered FIFO storage.
//   - Pop on MemWrite && MemReady. Head is stable while MemReady=0.
//   - Push and pop in the same cycle are legal; the count is unchanged.
//   - Minimum latency: Done edge sampled at edge t -> MemWrite=1 in cycle t+1.
//   - Pointers wrap modulo DEPTH.
// CONFIGURATION
//  DIAG_WB_STATS_EN defined
//   - Adds out WriteCount[15:0]: increments on every accepted write.
//   - Adds out StallCount[15:0]: increments on every cycle with MemWrite && !MemReady.
//   - Both counters saturate at 16'hFFFF and reset to 0.
//  DIAG_WB_STATS_EN undefined
//   - Ports and counters are absent; all other behaviour is identical.
// TESTING
//  T1
//   - Stimulus: Start (XAddr=5, YAddr=9); XDone rises t=3 with 48'h0000_3F80_0000; YDone rises t=6; MemReady=1.
//   - Response: write X@5 in cycle 4, write Y@9 in cycle 7; UpdateDone in cycle 8.
//  T2
//   - Stimulus: both Done rise in the same cycle t.
//   - Response: X written in cycle t+1, Y in cycle t+2, single UpdateDone.
//  T3
//   - Stimulus: MemReady=0 for 5 cycles after the first MemWrite.
//   - Response: MemAddr/MemData/MemSel stable; no UpdateDone until both writes are accepted; StallCount=5 (STATS_EN).
//  T4
//   - Stimulus: XDone rises in IDLE; then XDone pulses twice in WAIT_DONE.
//   - Response: Error=1 after the IDLE edge; only one X write; Error stays 1.
//  T5
//   - Stimulus: reset asserted while one entry is queued and MemReady=0.
//   - Response: next cycle MemWrite=0, StartReady=1, Error=0; no write is issued later.
//  T6
//   - Stimulus: Start asserted during WAIT_WRITE.
//   - Response: ignored; addresses unchanged; the next update starts only after UpdateDone.

Source files
------------

// File: rtl/diagonal_writeback.sv
// Tags update_computation results with their diagonal address and writes them through one stalling port.
// Optional DIAG_WB_STATS_EN adds WriteCount/StallCount statistics outputs.
module diagonal_writeback #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] XAddr,
    input  logic [ADDR_W-1:0] YAddr,
    output logic              StartReady,
    input  logic [47:0]       NewDiagonalX,
    input  logic [47:0]       NewDiagonalY,
    input  logic              DiagonalXDone,
    input  logic              DiagonalYDone,
    output logic              MemWrite,
    output logic              MemSel,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [47:0]       MemData,
    input  logic              MemReady,
    output logic              UpdateDone,
    output logic              Error
`ifdef DIAG_WB_STATS_EN
    ,
    output logic [15:0]       WriteCount,
    output logic [15:0]       StallCount
`endif
);

    localparam int EW = 1 + ADDR_W + 48;
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        WAIT_WRITE
    } stateT;

    stateT state, stateNext;

    logic              xDonePrev, yDonePrev;
    logic              xEdge, yEdge;
    logic              gotX, gotY;
    logic [ADDR_W-1:0] xAddrReg, yAddrReg;
    logic              pendValid;
    logic [EW-1:0]     pendEntry;
    logic [EW-1:0]     fifoMem [DEPTH];
    logic [PW-1:0]     wrPtr, rdPtr;
    logic [PW:0]       count;
    logic              fifoEmpty, fifoFull;
    logic              push, pop;
    logic [EW-1:0]     pushEntry;
    logic              pendLoad, pendClear;
    logic [EW-1:0]     pendLoadEntry;
    logic              latchAddr, acceptX, acceptY, errSet;
    logic [EW-1:0]     entryX, entryY;

    assign xEdge     = DiagonalXDone & ~xDonePrev;
    assign yEdge     = DiagonalYDone & ~yDonePrev;
    assign entryX    = {1'b0, xAddrReg, NewDiagonalX};
    assign entryY    = {1'b1, yAddrReg, NewDiagonalY};
    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == FULL_COUNT);
    assign pop       = !fifoEmpty && MemReady;

    assign MemWrite  = !fifoEmpty;
    assign {MemSel, MemAddr, MemData} = fifoMem[rdPtr];

    always_comb begin
        stateNext  = state;
        StartReady = 1'b0;
        UpdateDone = 1'b0;
        latchAddr  = 1'b0;
        acceptX    = 1'b0;
        acceptY    = 1'b0;
        errSet     = 1'b0;
        unique case (state)
            IDLE: begin
                StartReady = 1'b1;
                errSet     = xEdge || yEdge;
                if (Start) begin
                    latchAddr = 1'b1;
                    stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                acceptX = xEdge && !gotX;
                acceptY = yEdge && !gotY;
                errSet  = (xEdge && gotX) || (yEdge && gotY);
                if (gotX && gotY)
                    stateNext = WAIT_WRITE;
            end
            WAIT_WRITE: begin
                // both results already taken, so any further edge is a duplicate
                errSet = xEdge || yEdge;
                if (fifoEmpty && !pendValid) begin
                    UpdateDone = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // one FIFO push per cycle: pending first, then X, then Y
    always_comb begin
        push          = 1'b0;
        pushEntry     = entryX;
        pendLoad      = 1'b0;
        pendLoadEntry = entryY;
        pendClear     = 1'b0;
        if (pendValid) begin
            if (!fifoFull) begin
                push      = 1'b1;
                pushEntry = pendEntry;
                pendClear = 1'b1;
            end
        end else if (acceptX) begin
            if (!fifoFull) begin
                push      = 1'b1;
                pushEntry = entryX;
                if (acceptY) begin
                    pendLoad      = 1'b1;
                    pendLoadEntry = entryY;
                end
            end else begin
                pendLoad      = 1'b1;
                pendLoadEntry = entryX;
            end
        end else if (acceptY) begin
            if (!fifoFull) begin
                push      = 1'b1;
                pushEntry = entryY;
            end else begin
                pendLoad      = 1'b1;
                pendLoadEntry = entryY;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            xDonePrev <= 1'b0;
            yDonePrev <= 1'b0;
            gotX      <= 1'b0;
            gotY      <= 1'b0;
            xAddrReg  <= '0;
            yAddrReg  <= '0;
            pendValid <= 1'b0;
            pendEntry <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            Error     <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                fifoMem[i] <= '0;
        end else begin
            state     <= stateNext;
            xDonePrev <= DiagonalXDone;
            yDonePrev <= DiagonalYDone;
            if (errSet)
                Error <= 1'b1;
            if (latchAddr) begin
                xAddrReg <= XAddr;
                yAddrReg <= YAddr;
                gotX     <= 1'b0;
                gotY     <= 1'b0;
            end else begin
                if (acceptX)
                    gotX <= 1'b1;
                if (acceptY)
                    gotY <= 1'b1;
            end
            if (pendLoad) begin
                pendValid <= 1'b1;
                pendEntry <= pendLoadEntry;
            end else if (pendClear) begin
                pendValid <= 1'b0;
            end
            if (push) begin
                fifoMem[wrPtr] <= pushEntry;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DIAG_WB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            WriteCount <= '0;
            StallCount <= '0;
        end else begin
            if (pop && WriteCount != 16'hFFFF)
                WriteCount <= WriteCount + 16'd1;
            if (MemWrite && !MemReady && StallCount != 16'hFFFF)
                StallCount <= StallCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_diagonal_writeback.sv
// Bench for diagonal_writeback: directed vector table, hand sequences, randomized updates.
// Expected writes come from a per-update queue built from the stimulus.
module tb_diagonal_writeback;

    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          Start = 1'b0;
    logic [AW-1:0] XAddr = '0;
    logic [AW-1:0] YAddr = '0;
    logic          StartReady;
    logic [47:0]   NewDiagonalX = '0;
    logic [47:0]   NewDiagonalY = '0;
    logic          DiagonalXDone = 1'b0;
    logic          DiagonalYDone = 1'b0;
    logic          MemWrite;
    logic          MemSel;
    logic [AW-1:0] MemAddr;
    logic [47:0]   MemData;
    logic          MemReady = 1'b1;
    logic          UpdateDone;
    logic          Error;
`ifdef DIAG_WB_STATS_EN
    logic [15:0]   WriteCount;
    logic [15:0]   StallCount;
    logic [15:0]   wc0, sc0;
`endif

    int total = 0;
    int bad   = 0;

    diagonal_writeback #(.ADDR_W(AW), .DEPTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .Start(Start),
        .XAddr(XAddr),
        .YAddr(YAddr),
        .StartReady(StartReady),
        .NewDiagonalX(NewDiagonalX),
        .NewDiagonalY(NewDiagonalY),
        .DiagonalXDone(DiagonalXDone),
        .DiagonalYDone(DiagonalYDone),
        .MemWrite(MemWrite),
        .MemSel(MemSel),
        .MemAddr(MemAddr),
        .MemData(MemData),
        .MemReady(MemReady),
        .UpdateDone(UpdateDone),
        .Error(Error)
`ifdef DIAG_WB_STATS_EN
        ,
        .WriteCount(WriteCount),
        .StallCount(StallCount)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int xAt;
        int yAt;
        int xAgain;
        int stall;
        int startAt;
        bit idleEdge;
        int expDone;
        bit expErr;
    } vecT;

    vecT vecs[7];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Done pulses are sampled at edge xAt/yAt counted from the Start edge.
    task automatic runUpdate(input int xAt, input int yAt, input int xAgain, input int stall,
                             input int startAt, input bit rnd, input int expDone,
                             input string tag);
        logic [AW-1:0] xa, ya;
        logic [47:0]   xd, yd;
        logic [58:0]   expQ[$];
        logic [58:0]   want, prevHead;
        bit            prevStall;
        int            first, doneCyc, nWr;
        xa = AW'($urandom);
        ya = AW'($urandom);
        xd = 48'({$urandom, $urandom});
        yd = 48'({$urandom, $urandom});
        first = (xAt <= yAt) ? xAt : yAt;
        if (xAt <= yAt) begin
            expQ.push_back({1'b0, xa, xd});
            expQ.push_back({1'b1, ya, yd});
        end else begin
            expQ.push_back({1'b1, ya, yd});
            expQ.push_back({1'b0, xa, xd});
        end
        Start = 1'b1;
        XAddr = xa;
        YAddr = ya;
        tick();
        Start = 1'b0;
        doneCyc = -1;
        nWr = 0;
        prevStall = 1'b0;
        prevHead = '0;
        for (int c = 0; c < 80; c++) begin
            DiagonalXDone = (c + 1 == xAt) || (c + 1 == xAgain);
            DiagonalYDone = (c + 1 == yAt);
            NewDiagonalX = (c + 1 == xAt) ? xd : 48'({$urandom, $urandom});
            NewDiagonalY = (c + 1 == yAt) ? yd : 48'({$urandom, $urandom});
            Start = (c == startAt);
            XAddr = (c == startAt) ? ~xa : xa;
            YAddr = (c == startAt) ? ~ya : ya;
            MemReady = rnd ? ($urandom_range(0, 3) != 0) : !(c >= first && c < first + stall);
            if (c == startAt)
                check({tag, "_busy"}, StartReady, 0);
            if (prevStall)
                check({tag, "_hold"}, {MemSel, MemAddr, MemData}, prevHead);
            prevStall = MemWrite && !MemReady;
            prevHead = {MemSel, MemAddr, MemData};
            if (MemWrite && MemReady) begin
                nWr++;
                if (expQ.size() == 0) begin
                    check({tag, "_extra"}, 1, 0);
                end else begin
                    want = expQ.pop_front();
                    check({tag, "_wr"}, {MemSel, MemAddr, MemData}, want);
                end
            end
            if (UpdateDone) begin
                doneCyc = c;
                break;
            end
            tick();
        end
        Start = 1'b0;
        XAddr = xa;
        YAddr = ya;
        DiagonalXDone = 1'b0;
        DiagonalYDone = 1'b0;
        MemReady = 1'b1;
        check({tag, "_doneSeen"}, doneCyc >= 0, 1);
        if (expDone >= 0)
            check({tag, "_doneCyc"}, doneCyc, expDone);
        check({tag, "_nWr"}, nWr, 2);
        check({tag, "_readyAtDone"}, StartReady, 0);
        tick();
        check({tag, "_readyAfter"}, StartReady, 1);
        check({tag, "_donePulse"}, UpdateDone, 0);
        check({tag, "_idleWr"}, MemWrite, 0);
    endtask

    initial begin
        bit seenWr;
        vecs[0] = '{3, 6, 0, 0, -1, 1'b0, 7, 1'b0};
        vecs[1] = '{4, 4, 0, 0, -1, 1'b0, 6, 1'b0};
        vecs[2] = '{2, 3, 0, 5, -1, 1'b0, 9, 1'b0};
        vecs[3] = '{5, 2, 0, 0, -1, 1'b0, 6, 1'b0};
        vecs[4] = '{2, 3, 0, 2, -1, 1'b0, 6, 1'b0};
        vecs[5] = '{1, 2, 0, 4, 4, 1'b0, 7, 1'b0};
        vecs[6] = '{1, 5, 3, 0, -1, 1'b1, 6, 1'b1};

        repeat (3) tick();
        check("rst_startReady", StartReady, 1);
        check("rst_memWrite", MemWrite, 0);
        check("rst_head", {MemSel, MemAddr, MemData}, 0);
        check("rst_updateDone", UpdateDone, 0);
        check("rst_error", Error, 0);
`ifdef DIAG_WB_STATS_EN
        check("rst_counts", {WriteCount, StallCount}, 0);
`endif
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
`ifdef DIAG_WB_STATS_EN
            wc0 = WriteCount;
            sc0 = StallCount;
`endif
            if (vecs[i].idleEdge) begin
                DiagonalXDone = 1'b1;
                tick();
                DiagonalXDone = 1'b0;
                tick();
                check("idle_err", Error, 1);
                check("idle_noPush", MemWrite, 0);
            end
            runUpdate(vecs[i].xAt, vecs[i].yAt, vecs[i].xAgain, vecs[i].stall,
                      vecs[i].startAt, 1'b0, vecs[i].expDone, $sformatf("row%0d", i));
            check($sformatf("row%0d_err", i), Error, vecs[i].expErr);
`ifdef DIAG_WB_STATS_EN
            check($sformatf("row%0d_wcnt", i), WriteCount - wc0, 2);
            check($sformatf("row%0d_scnt", i), StallCount - sc0, vecs[i].stall);
`endif
        end

        // reset with one entry queued behind a stalled port
        Start = 1'b1;
        XAddr = 10'd7;
        YAddr = 10'd8;
        tick();
        Start = 1'b0;
        DiagonalXDone = 1'b1;
        NewDiagonalX = 48'h0000_3F80_0000;
        MemReady = 1'b0;
        tick();
        DiagonalXDone = 1'b0;
        check("t5_queued", MemWrite, 1);
        reset = 1'b1;
        tick();
        check("t5_memWrite", MemWrite, 0);
        check("t5_startReady", StartReady, 1);
        check("t5_error", Error, 0);
        reset = 1'b0;
        MemReady = 1'b1;
        seenWr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (MemWrite || UpdateDone)
                seenWr = 1'b1;
        end
        check("t5_noLateWrite", seenWr, 0);

        for (int i = 0; i < 40; i++)
            runUpdate($urandom_range(1, 6), $urandom_range(1, 6), 0, 0,
                      $urandom_range(0, 12), 1'b1, -1, $sformatf("rnd%0d", i));
        check("rnd_error", Error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
